// File: rtl/snn_pkg.sv
// Shared widths for the SNN neuron datapath (u/b processor and its neighbours).
package snn_pkg;

  localparam int unsigned POT_W  = 8;
  localparam int unsigned BETA_W = 4;

  typedef logic [POT_W-1:0]  pot_t;
  typedef logic [BETA_W-1:0] beta_t;

endpackage : snn_pkg

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for the leak multiplier: master drives operands, slave returns results.
interface shift_add_mult_if #(
  parameter int unsigned POT_W  = snn_pkg::POT_W,
  parameter int unsigned BETA_W = snn_pkg::BETA_W
);

  logic              in_valid;
  logic [BETA_W-1:0] beta;
  logic [POT_W-1:0]  potential;
  logic              out_valid;
  logic [POT_W-1:0]  mult_ans;

  modport master (
    output in_valid, beta, potential,
    input  out_valid, mult_ans
  );

  modport slave (
    input  in_valid, beta, potential,
    output out_valid, mult_ans
  );

endinterface : shift_add_mult_if

// File: rtl/shift_add_mult.sv
// Two-stage shift-and-add leak multiplier: mult_ans = floor(potential * beta / 2^BETA_W).
module shift_add_mult
  import snn_pkg::*;
#(
  parameter int unsigned POT_W  = snn_pkg::POT_W,
  parameter int unsigned BETA_W = snn_pkg::BETA_W
) (
  input  logic            clk,
  input  logic            reset,
  shift_add_mult_if.slave bus
);

  localparam int unsigned LO_BITS = BETA_W / 2;
  localparam int unsigned HI_BITS = BETA_W - LO_BITS;
  localparam int unsigned LO_W    = POT_W + LO_BITS;
  localparam int unsigned PROD_W  = POT_W + BETA_W;

  // Gated partial products; low half kept narrow since it cannot exceed LO_W bits
  logic [LO_W-1:0]   pp_lo [LO_BITS];
  logic [PROD_W-1:0] pp_hi [HI_BITS];

  for (genvar k = 0; k < BETA_W; k++) begin : g_pp
    if (k < LO_BITS) begin : g_lo
      assign pp_lo[k] = bus.beta[k] ? (LO_W'(bus.potential) << k) : '0;
    end else begin : g_hi
      assign pp_hi[k - LO_BITS] = bus.beta[k] ? (PROD_W'(bus.potential) << k) : '0;
    end
  end

  logic [LO_W-1:0]   lo_d, lo_q;
  logic [PROD_W-1:0] hi_d, hi_q;
  logic              v1_q;
  logic [PROD_W-1:0] sum_c;
  logic [POT_W-1:0]  mult_ans_d, mult_ans_q;
  logic              out_valid_q;

  always_comb begin
    lo_d = '0;
    hi_d = '0;
    for (int unsigned k = 0; k < LO_BITS; k++) lo_d = lo_d + pp_lo[k];
    for (int unsigned k = 0; k < HI_BITS; k++) hi_d = hi_d + pp_hi[k];
  end

  // Full-width add, then drop the BETA_W fractional bits (truncation, no rounding)
  always_comb begin
    sum_c      = PROD_W'(lo_q) + hi_q;
    mult_ans_d = POT_W'(sum_c >> BETA_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q        <= '0;
      hi_q        <= '0;
      v1_q        <= 1'b0;
      mult_ans_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= bus.in_valid;
      out_valid_q <= v1_q;
      if (bus.in_valid) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
      if (v1_q) mult_ans_q <= mult_ans_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mult_ans  = mult_ans_q;

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: directed corners, exhaustive sweep, random stream, bubbles, mid-stream reset.
module tb_shift_add_mult;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a result becomes visible one edge after the edge that sampled it
  logic       pend_v;
  logic [7:0] pend_ans;
  logic       exp_v;
  logic [7:0] exp_ans;

  shift_add_mult_if bus ();

  shift_add_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_mult(input int p, input int b);
    return 8'((p * b) / 16);
  endfunction

  // One clock: drive operands, advance model across the edge, compare #1 after it
  task automatic step(input logic v, input int p, input int b, input string tag);
    bus.in_valid  = v;
    bus.potential = 8'(p);
    bus.beta      = 4'(b);
    @(posedge clk);
    exp_v = pend_v;
    if (pend_v) exp_ans = pend_ans;
    pend_v   = v;
    pend_ans = ref_mult(p, b);
    #1;
    check({tag, "_valid"}, int'(bus.out_valid), int'(exp_v));
    check({tag, "_ans"},   int'(bus.mult_ans),  int'(exp_ans));
  endtask

  task automatic model_reset();
    pend_v   = 1'b0;
    pend_ans = '0;
    exp_v    = 1'b0;
    exp_ans  = '0;
  endtask

  task automatic directed(input int p, input int b, input int want, input string tag);
    step(1'b1, p, b, tag);
    step(1'b0, 0, 0, tag);
    check({tag, "_lat_valid"}, int'(bus.out_valid), 1);
    check({tag, "_const"},     int'(bus.mult_ans),  want);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.potential = '0;
    bus.beta      = '0;
    model_reset();
    reset = 1'b1;
    #2;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_ans",   int'(bus.mult_ans),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    directed(200, 8,  100, "decay");
    directed(255, 15, 239, "max_trunc");
    directed(1,   15, 0,   "tiny");
    directed(100, 0,  0,   "beta0");
    directed(0,   15, 0,   "pot0");

    // Exhaustive back-to-back sweep, then drain
    for (int p = 0; p < 256; p++)
      for (int b = 0; b < 16; b++)
        step(1'b1, p, b, "sweep");
    step(1'b0, 0, 0, "sweep_drain");
    step(1'b0, 0, 0, "sweep_drain");

    // Bubble pattern 1,0,1,1 with nonzero results so the hold is observable
    step(1'b1, 180, 11, "bubble");
    step(1'b0, 77,  9,  "bubble");
    step(1'b1, 250, 13, "bubble");
    step(1'b1, 64,  5,  "bubble");
    step(1'b0, 0,   0,  "bubble");
    step(1'b0, 0,   0,  "bubble");
    step(1'b0, 0,   0,  "bubble");

    // Random stream with random gaps
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
           int'($urandom_range(15, 0)), "rand");

    // Asynchronous reset with two operations in flight
    step(1'b1, 240, 14, "pre_rst");
    step(1'b1, 250, 15, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_ans",   int'(bus.mult_ans),  0);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_rst_valid", int'(bus.out_valid), 0);
    check("hold_rst_ans",   int'(bus.mult_ans),  0);
    reset = 1'b0;
    step(1'b1, 200, 6, "post_rst");
    step(1'b0, 0,   0, "post_rst");
    step(1'b0, 0,   0, "post_rst");
    check("post_rst_const", int'(bus.mult_ans), 75);

    for (int i = 0; i < 50; i++)
      step(1'b1, int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), "tail");
    step(1'b0, 0, 0, "tail_drain");
    step(1'b0, 0, 0, "tail_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_add_mult

// File: doc/shift_add_mult.md
# shift_add_mult

Pipelined fixed-point shift-and-add multiplier that applies the leak factor beta to a neuron membrane potential. It computes `mult_ans = floor(potential × beta / 2^BETA_W)`, where beta is an unsigned pure fraction (Q0.4). It is instantiated once per neuron lane, 16 per processor, on the potential-load path of the u/b processor, before the decayed potential is reused.

## Interface
Parameters:
- `POT_W`, default 8: potential and result width (unsigned).
- `BETA_W`, default 4: beta width; beta is interpreted as `beta / 2^BETA_W`.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears the whole pipeline.
- `in_valid`  input  1  `beta` and `potential` are valid this cycle.
- `beta`  input  BETA_W  unsigned fractional leak factor, 0 to 15/16.
- `potential`  input  POT_W  unsigned membrane potential.
- `out_valid`  output  1  `mult_ans` holds a new result.
- `mult_ans`  output  POT_W  decayed potential.

## Operation
- Full product: P = Σ over k of (`potential` << k), for every k where `beta[k]` = 1. P is POT_W+BETA_W bits (12) and cannot overflow.
- Result: `mult_ans` = P[POT_W+BETA_W-1 : BETA_W]. This is truncation toward zero, with no rounding.
- Result range: the result is always ≤ `potential`, so no saturation logic is needed.
  - `beta` = 0 gives 0.
  - `potential` = 0 gives 0.
- Stage 1, on a rising edge with `in_valid` = 1:
  - Register the low partial sum `potential × beta[1:0]` (POT_W+2 bits).
  - Register the high partial sum `(potential × beta[3:2]) << 2` (POT_W+BETA_W bits).
  - Register `v1` = `in_valid`.
  - When `in_valid` = 0, `v1` = 0 and the stage-1 data registers hold their previous value.
- Stage 2, when `v1` = 1:
  - Add the two partial sums at full width.
  - Register the upper POT_W bits into `mult_ans`.
  - Register `out_valid` = `v1`.
- No multiplier primitive (`*`) is allowed. Use only gated shifts and adders.
- There is no backpressure. The block accepts one operation per cycle unconditionally.

## Timing
- Latency:
  - Inputs sampled at edge N produce their result on `mult_ans`, with `out_valid` = 1, after edge N+1.
  - The result is visible in cycle N+2.
- Throughput: one result per clock. Back-to-back `in_valid` pulses produce back-to-back `out_valid` pulses in the same order.
- When `out_valid` = 0, `mult_ans` holds its last value.
- Reset values, applied immediately on `reset` assertion regardless of the clock:
  - `out_valid` = 0.
  - `mult_ans` = 0.
  - All partial-sum registers = 0.
  - `v1` = 0.
- Reset mid-stream: in-flight operations are discarded and produce no `out_valid`.
- First valid input after release: an input sampled at the first rising edge after `reset` deasserts is processed normally.
- Bubbles: an `in_valid` gap produces an `out_valid` gap exactly two cycles later.

## Structure
- Shared package `snn_pkg`:
  - `POT_W` = 8.
  - `BETA_W` = 4.
  - The potential and beta widths are also used by u_b_processor and its neighbours.
- Sub-modules: none. The block is a single module of two register stages, with the partial products generated in a `generate` loop over the beta bits.

## Test plan
- Basic decay: `potential` = 200, `beta` = 8 → `mult_ans` = 100, with `out_valid` two cycles later.
- Maximum truncation: `potential` = 255, `beta` = 15 → 239. `potential` = 1, `beta` = 15 → 0.
- Zero operands: `beta` = 0 with `potential` = 100 → 0. `potential` = 0 with `beta` = 15 → 0.
- Full stream: exhaustive sweep of all 4096 (`potential`, `beta`) pairs back-to-back, one per cycle. Each output matches `floor(p×b/16)` in order, with no gaps.
- Bubbles: `in_valid` pattern 1,0,1,1 → `out_valid` pattern 1,0,1,1 delayed by 2. `mult_ans` holds during the gap.
- Reset mid-stream: assert `reset` asynchronously between edges while two operations are in flight. `out_valid` and `mult_ans` go to 0 immediately, no stale result ever appears, and the first post-reset input is processed correctly.
